// File: rtl/fpaddsub_unpack_align.sv
// ---------------------------------------------------------------------------
// fpaddsub_unpack_align
//   Front end of the binary32 add/sub datapath. It unpacks both operands,
//   classifies special values, orders them by magnitude and right-aligns the
//   smaller mantissa with guard/round/sticky bits for the adder stage.
//
//   Stage 1 (registered): unpack, flush denormals, compare, classify.
//   Stage 2 (registered): alignment shift with sticky collection.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   InValid / InReady   operand-side handshake
//   A, B, Ctrl          binary32 operands, 0 = A+B, 1 = A-B
//   OutValid / OutReady result-side handshake
//   Sa, Sb, CtrlO       operand signs and control as received
//   MaxAB               1 when |B| > |A| (operands swapped)
//   OpEff               effective subtract
//   MaxE, MaxM          exponent / mantissa (hidden bit included) of larger
//   AlignM              {smaller mantissa >> diff, G, R, S}
//   ExcNaN, ExcInf      special-value result flags
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. Each stage advances when it is empty or its consumer is taking its
// item this cycle (adv2 = ~v2 | OutReady, adv1 = ~v1 | adv2); InReady = adv1.
// A stalled stage holds its contents. InReady depends only on stage state and
// OutReady, never on A/B.
// ---------------------------------------------------------------------------
module fpaddsub_unpack_align #(
    parameter int unsigned SHIFT_SAT = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        InValid,
    output logic        InReady,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Ctrl,
    output logic        OutValid,
    input  logic        OutReady,
    output logic        Sa,
    output logic        Sb,
    output logic        CtrlO,
    output logic        MaxAB,
    output logic        OpEff,
    output logic [7:0]  MaxE,
    output logic [23:0] MaxM,
    output logic [26:0] AlignM,
    output logic        ExcNaN,
    output logic        ExcInf
);

    localparam logic [7:0] SAT_E = 8'(SHIFT_SAT);

    logic adv1, adv2;

    // ---------------- stage 1: unpack / compare / classify ----------------
    logic        v1_q;
    logic        s1_sa_q, s1_sb_q, s1_ctrl_q, s1_swap_q, s1_opeff_q;
    logic [7:0]  s1_maxe_q, s1_mine_q;
    logic [23:0] s1_maxm_q, s1_minm_q;
    logic        s1_nan_q, s1_inf_q;

    logic [7:0]  ea, eb;
    logic [23:0] ma, mb;
    logic        swap_d, opeff_d, nan_a, nan_b, inf_a, inf_b, nan_d, inf_d;

    always_comb begin
        ea = A[30:23];
        eb = B[30:23];
        // Zero exponent (zero or denormal) flushes the whole mantissa to 0.
        ma = (ea != 8'd0) ? {1'b1, A[22:0]} : 24'd0;
        mb = (eb != 8'd0) ? {1'b1, B[22:0]} : 24'd0;
        swap_d  = {eb, mb} > {ea, ma};
        opeff_d = A[31] ^ B[31] ^ Ctrl;
        nan_a   = (ea == 8'hFF) && (A[22:0] != 23'd0);
        nan_b   = (eb == 8'hFF) && (B[22:0] != 23'd0);
        inf_a   = (ea == 8'hFF) && (A[22:0] == 23'd0);
        inf_b   = (eb == 8'hFF) && (B[22:0] == 23'd0);
        // Opposite infinities under an effective subtract have no value.
        nan_d   = nan_a | nan_b | (inf_a & inf_b & opeff_d);
        inf_d   = ~nan_d & (inf_a | inf_b);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q       <= 1'b0;
            s1_sa_q    <= 1'b0;
            s1_sb_q    <= 1'b0;
            s1_ctrl_q  <= 1'b0;
            s1_swap_q  <= 1'b0;
            s1_opeff_q <= 1'b0;
            s1_maxe_q  <= 8'd0;
            s1_mine_q  <= 8'd0;
            s1_maxm_q  <= 24'd0;
            s1_minm_q  <= 24'd0;
            s1_nan_q   <= 1'b0;
            s1_inf_q   <= 1'b0;
        end else if (adv1) begin
            v1_q <= InValid;
            if (InValid) begin
                s1_sa_q    <= A[31];
                s1_sb_q    <= B[31];
                s1_ctrl_q  <= Ctrl;
                s1_swap_q  <= swap_d;
                s1_opeff_q <= opeff_d;
                s1_maxe_q  <= swap_d ? eb : ea;
                s1_mine_q  <= swap_d ? ea : eb;
                s1_maxm_q  <= swap_d ? mb : ma;
                s1_minm_q  <= swap_d ? ma : mb;
                s1_nan_q   <= nan_d;
                s1_inf_q   <= inf_d;
            end
        end
    end

    // ---------------- stage 2: alignment shift ----------------------------
    logic        v2_q;
    logic [26:0] align_d;
    logic [26:0] ext, shifted, lost_mask;
    logic [7:0]  diff;

    always_comb begin
        diff      = s1_maxe_q - s1_mine_q;   // ordered, so never negative
        ext       = {s1_minm_q, 3'b000};
        shifted   = ext >> diff;
        lost_mask = (27'd1 << diff) - 27'd1;
        if (diff >= SAT_E) begin
            // Whole mantissa falls past the sticky position.
            align_d = {26'd0, |s1_minm_q};
        end else begin
            align_d = shifted | {26'd0, |(ext & lost_mask)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q   <= 1'b0;
            Sa     <= 1'b0;
            Sb     <= 1'b0;
            CtrlO  <= 1'b0;
            MaxAB  <= 1'b0;
            OpEff  <= 1'b0;
            MaxE   <= 8'd0;
            MaxM   <= 24'd0;
            AlignM <= 27'd0;
            ExcNaN <= 1'b0;
            ExcInf <= 1'b0;
        end else if (adv2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                Sa     <= s1_sa_q;
                Sb     <= s1_sb_q;
                CtrlO  <= s1_ctrl_q;
                MaxAB  <= s1_swap_q;
                OpEff  <= s1_opeff_q;
                MaxE   <= s1_maxe_q;
                MaxM   <= s1_maxm_q;
                AlignM <= align_d;
                ExcNaN <= s1_nan_q;
                ExcInf <= s1_inf_q;
            end
        end
    end

    assign adv2     = ~v2_q | OutReady;
    assign adv1     = ~v1_q | adv2;
    assign InReady  = adv1;
    assign OutValid = v2_q;

endmodule

// File: tb/tb_fpaddsub_unpack_align.sv
module tb_fpaddsub_unpack_align;
  localparam int EW = 66;
  localparam int NV = 13;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        InValid, InReady, Ctrl, OutValid, OutReady;
  logic [31:0] A, B;
  logic        Sa, Sb, CtrlO, MaxAB, OpEff, ExcNaN, ExcInf;
  logic [7:0]  MaxE;
  logic [23:0] MaxM;
  logic [26:0] AlignM;

  fpaddsub_unpack_align dut (
    .clk(clk), .rst_n(rst_n), .InValid(InValid), .InReady(InReady),
    .A(A), .B(B), .Ctrl(Ctrl), .OutValid(OutValid), .OutReady(OutReady),
    .Sa(Sa), .Sb(Sb), .CtrlO(CtrlO), .MaxAB(MaxAB), .OpEff(OpEff),
    .MaxE(MaxE), .MaxM(MaxM), .AlignM(AlignM), .ExcNaN(ExcNaN), .ExcInf(ExcInf)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad = 0;
  logic [EW-1:0] exp_q[$];

  logic [31:0]   va[NV];
  logic [31:0]   vb[NV];
  logic          vc[NV];
  logic [EW-1:0] ve[NV];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk_exp(
    input logic sa, input logic sb, input logic c, input logic maxab, input logic opeff,
    input logic [7:0] maxe, input logic [23:0] maxm, input logic [26:0] alm,
    input logic nan, input logic inf);
    return {sa, sb, c, maxab, opeff, maxe, maxm, alm, nan, inf};
  endfunction

  task automatic set_vec(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic c, input logic [EW-1:0] e);
    va[i] = a; vb[i] = b; vc[i] = c; ve[i] = e;
  endtask

  // Hand-computed directed vectors.
  task automatic init_vecs();
    set_vec(0,  32'h3F800000, 32'h40000000, 1'b0, mk_exp(0,0,0,1,0, 8'h80, 24'h800000, 27'h2000000, 0,0));
    set_vec(1,  32'h4F000000, 32'h3F800001, 1'b0, mk_exp(0,0,0,0,0, 8'h9E, 24'h800000, 27'h0000001, 0,0));
    set_vec(2,  32'h40400000, 32'hC0400000, 1'b0, mk_exp(0,1,0,0,1, 8'h80, 24'hC00000, 27'h6000000, 0,0));
    set_vec(3,  32'h7F800000, 32'hFF800000, 1'b0, mk_exp(0,1,0,0,1, 8'hFF, 24'h800000, 27'h4000000, 1,0));
    set_vec(4,  32'h7F800000, 32'h3F800000, 1'b0, mk_exp(0,0,0,0,0, 8'hFF, 24'h800000, 27'h0000001, 0,1));
    set_vec(5,  32'h00000001, 32'h3F800000, 1'b1, mk_exp(0,0,1,1,1, 8'h7F, 24'h800000, 27'h0000000, 0,0));
    set_vec(6,  32'h3F800000, 32'h33000001, 1'b0, mk_exp(0,0,0,0,0, 8'h7F, 24'h800000, 27'h0000003, 0,0));
    set_vec(7,  32'h3F800000, 32'h32800000, 1'b0, mk_exp(0,0,0,0,0, 8'h7F, 24'h800000, 27'h0000001, 0,0));
    set_vec(8,  32'h7FC00000, 32'h3F800000, 1'b0, mk_exp(0,0,0,0,0, 8'hFF, 24'hC00000, 27'h0000001, 1,0));
    set_vec(9,  32'h7F800000, 32'h7F800000, 1'b1, mk_exp(0,0,1,0,1, 8'hFF, 24'h800000, 27'h4000000, 1,0));
    set_vec(10, 32'h7F800000, 32'h7F800000, 1'b0, mk_exp(0,0,0,0,0, 8'hFF, 24'h800000, 27'h4000000, 0,1));
    set_vec(11, 32'h41800000, 32'h3F800001, 1'b0, mk_exp(0,0,0,0,0, 8'h83, 24'h800000, 27'h0400001, 0,0));
    set_vec(12, 32'hBF800000, 32'h40000000, 1'b1, mk_exp(1,0,1,1,0, 8'h80, 24'h800000, 27'h2000000, 0,0));
  endtask

  // ---------------- driver ----------------
  task automatic send(input int i);
    int n = 0;
    A = va[i]; B = vb[i]; Ctrl = vc[i]; InValid = 1'b1;
    forever begin
      @(negedge clk);
      if (InReady) begin
        exp_q.push_back(ve[i]);
        break;
      end
      n++;
      if (n > 50) begin
        check_eq("send_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    InValid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst_n && OutValid && OutReady) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_out", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("Sa",     32'(Sa),     32'(e[65]));
        check_eq("Sb",     32'(Sb),     32'(e[64]));
        check_eq("CtrlO",  32'(CtrlO),  32'(e[63]));
        check_eq("MaxAB",  32'(MaxAB),  32'(e[62]));
        check_eq("OpEff",  32'(OpEff),  32'(e[61]));
        check_eq("MaxE",   32'(MaxE),   32'(e[60:53]));
        check_eq("MaxM",   32'(MaxM),   32'(e[52:29]));
        check_eq("AlignM", 32'(AlignM), 32'(e[28:2]));
        check_eq("ExcNaN", 32'(ExcNaN), 32'(e[1]));
        check_eq("ExcInf", 32'(ExcInf), 32'(e[0]));
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    InValid = 1'b0; A = 32'd0; B = 32'd0; Ctrl = 1'b0; OutReady = 1'b1;
    init_vecs();

    // Reset state
    #2;
    check_eq("rst_outvalid", 32'(OutValid), 32'd0);
    check_eq("rst_maxe",     32'(MaxE),     32'd0);
    check_eq("rst_alignm",   32'(AlignM),   32'd0);
    check_eq("rst_excnan",   32'(ExcNaN),   32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_inready", 32'(InReady), 32'd1);
    @(posedge clk); #1;

    // Latency: presented in cycle 0, visible in cycle 2
    send(0);
    @(negedge clk);
    check_eq("lat_cycle1", 32'(OutValid), 32'd0);
    @(negedge clk);
    check_eq("lat_cycle2", 32'(OutValid), 32'd1);
    drain();

    // Back-to-back stream of all vectors
    @(posedge clk); #1;
    for (int i = 1; i < NV; i++) send(i);
    drain();

    // Stall: two accepted, InReady drops, outputs hold
    @(posedge clk); #1;
    OutReady = 1'b0;
    send(0);
    send(1);
    A = va[2]; B = vb[2]; Ctrl = vc[2]; InValid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("stall_inready",  32'(InReady),  32'd0);
      check_eq("stall_outvalid", 32'(OutValid), 32'd1);
      check_eq("stall_maxe",     32'(MaxE),     32'h80);
      check_eq("stall_alignm",   32'(AlignM),   32'h2000000);
    end
    @(posedge clk); #1;
    OutReady = 1'b1;
    fork
      begin
        send(2);
        send(3);
      end
      begin
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check_eq("release_consec", 32'(OutValid), 32'd1);
        end
      end
    join
    drain();

    // Reset with both stages full
    @(posedge clk); #1;
    OutReady = 1'b0;
    send(4);
    send(5);
    @(negedge clk);
    check_eq("full_outvalid", 32'(OutValid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_outvalid", 32'(OutValid), 32'd0);
    check_eq("midrst_inready",  32'(InReady),  32'd1);
    check_eq("midrst_maxe",     32'(MaxE),     32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    OutReady = 1'b1;
    @(negedge clk);
    check_eq("postrst_inready",  32'(InReady),  32'd1);
    check_eq("postrst_outvalid", 32'(OutValid), 32'd0);
    @(posedge clk); #1;
    send(6);
    drain();

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
